// File: rtl/fetch_unit_32.sv
// Instruction fetch sequencer: drives an external increment-capable PC register
// and a request/ack instruction memory, presenting one instruction at a time to the decoder.
module fetch_unit_32 #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] PC,
  output logic        PCWrite,
  output logic        PCIncrement,
  output logic [31:0] PCLoad,
  output logic        MemReq,
  output logic [31:0] MemAddr,
  input  logic        MemAck,
  input  logic [31:0] MemData,
  output logic        InstrValid,
  output logic [31:0] Instr,
  output logic [31:0] InstrPC,
  input  logic        InstrReady,
  input  logic        Redirect,
  input  logic [31:0] RedirectTarget
);

  localparam logic [1:0] INIT  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] VALID = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]  state;
  logic [1:0]  nextState;
  logic [31:0] addrHold;
  logic        capture;

  // Redirect always wins over increment; a request left unacked by a redirect
  // is kept alive in DRAIN at its original address until memory answers.
  always_comb begin
    nextState   = state;
    PCWrite     = 1'b0;
    PCIncrement = 1'b0;
    PCLoad      = RedirectTarget;
    MemReq      = 1'b0;
    MemAddr     = addrHold;
    InstrValid  = 1'b0;
    capture     = 1'b0;
    case (state)
      INIT: begin
        PCWrite   = 1'b1;
        PCLoad    = RESET_PC;
        nextState = FETCH;
      end
      FETCH: begin
        MemReq  = 1'b1;
        MemAddr = PC;
        if (Redirect) begin
          PCWrite   = 1'b1;
          nextState = MemAck ? FETCH : DRAIN;
        end else if (MemAck) begin
          PCWrite     = 1'b1;
          PCIncrement = 1'b1;
          capture     = 1'b1;
          nextState   = VALID;
        end
      end
      VALID: begin
        InstrValid = 1'b1;
        if (Redirect) begin
          PCWrite   = 1'b1;
          nextState = FETCH;
        end else if (InstrReady) begin
          nextState = FETCH;
        end
      end
      DRAIN: begin
        MemReq = 1'b1;
        if (Redirect) begin
          PCWrite = 1'b1;
        end
        if (MemAck) begin
          nextState = FETCH;
        end
      end
      default: nextState = INIT;
    endcase
    // Reset is synchronous, so outputs must be quiesced combinationally while it is held
    if (Reset) begin
      MemReq      = 1'b0;
      InstrValid  = 1'b0;
      PCWrite     = 1'b0;
      PCIncrement = 1'b0;
      capture     = 1'b0;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= INIT;
      Instr    <= 32'h0;
      InstrPC  <= 32'h0;
      addrHold <= 32'h0;
    end else begin
      state <= nextState;
      if (state == FETCH) begin
        addrHold <= PC;
      end
      if (capture) begin
        Instr   <= MemData;
        InstrPC <= PC;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit_32.sv
// Directed bench for fetch_unit_32; the environment models the external PC register
// and drives memory/decoder handshakes cycle by cycle against hand-computed values.
module tb_fetch_unit_32;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [31:0] PC;
  logic        PCWrite;
  logic        PCIncrement;
  logic [31:0] PCLoad;
  logic        MemReq;
  logic [31:0] MemAddr;
  logic        MemAck;
  logic [31:0] MemData;
  logic        InstrValid;
  logic [31:0] Instr;
  logic [31:0] InstrPC;
  logic        InstrReady;
  logic        Redirect;
  logic [31:0] RedirectTarget;

  int checks = 0;
  int errors = 0;

  fetch_unit_32 #(.RESET_PC(32'h00000000)) dut (
    .Clock(Clock), .Reset(Reset), .PC(PC),
    .PCWrite(PCWrite), .PCIncrement(PCIncrement), .PCLoad(PCLoad),
    .MemReq(MemReq), .MemAddr(MemAddr), .MemAck(MemAck), .MemData(MemData),
    .InstrValid(InstrValid), .Instr(Instr), .InstrPC(InstrPC), .InstrReady(InstrReady),
    .Redirect(Redirect), .RedirectTarget(RedirectTarget)
  );

  always #5 Clock = ~Clock;

  // External PC register that the fetch unit controls
  initial PC = 32'hDEAD0000;
  always @(posedge Clock) begin
    if (PCWrite) PC <= PCIncrement ? PC + 32'd1 : PCLoad;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge Clock);
    #2;
  endtask

  task automatic applyStimulus(input logic ack, input logic [31:0] data, input logic ready,
                               input logic redir, input logic [31:0] target);
    MemAck = ack; MemData = data; InstrReady = ready; Redirect = redir; RedirectTarget = target;
    #1;
  endtask

  initial begin
    Reset = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    cycle();
    cycle();
    checkOutput("rst_memreq", MemReq, 1'b0);
    checkOutput("rst_valid", InstrValid, 1'b0);
    checkOutput("rst_pcwrite", PCWrite, 1'b0);
    checkOutput("rst_instr", Instr, 32'h0);
    checkOutput("rst_instrpc", InstrPC, 32'h0);

    // INIT loads RESET_PC, ignoring redirect
    Reset = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h777);
    checkOutput("init_pcwrite", PCWrite, 1'b1);
    checkOutput("init_pcinc", PCIncrement, 1'b0);
    checkOutput("init_pcload", PCLoad, 32'h0);
    checkOutput("init_memreq", MemReq, 1'b0);
    cycle();

    // Back-to-back fetches with immediate ack
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'hA0000000 + i, 1'b0, 1'b0, 32'h0);
      checkOutput("seq_memreq", MemReq, 1'b1);
      checkOutput("seq_memaddr", MemAddr, i);
      checkOutput("seq_pcwrite", PCWrite, 1'b1);
      checkOutput("seq_pcinc", PCIncrement, 1'b1);
      cycle();
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      checkOutput("seq_valid", InstrValid, 1'b1);
      checkOutput("seq_instr", Instr, 32'hA0000000 + i);
      checkOutput("seq_instrpc", InstrPC, i);
      checkOutput("seq_valid_memreq", MemReq, 1'b0);
      checkOutput("seq_valid_pcwrite", PCWrite, 1'b0);
      cycle();
    end

    // Redirect with ack in FETCH: data dropped, stays in FETCH at 5
    applyStimulus(1'b1, 32'hBAD00003, 1'b0, 1'b1, 32'h5);
    checkOutput("rdack_pcwrite", PCWrite, 1'b1);
    checkOutput("rdack_pcinc", PCIncrement, 1'b0);
    checkOutput("rdack_pcload", PCLoad, 32'h5);
    cycle();

    // Ack delayed three cycles at PC=5
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      checkOutput("wait_memreq", MemReq, 1'b1);
      checkOutput("wait_memaddr", MemAddr, 32'h5);
      checkOutput("wait_pcwrite", PCWrite, 1'b0);
      checkOutput("wait_valid", InstrValid, 1'b0);
      cycle();
    end
    applyStimulus(1'b1, 32'h12345678, 1'b0, 1'b0, 32'h0);
    checkOutput("wait_ack_memaddr", MemAddr, 32'h5);
    checkOutput("wait_ack_pcinc", PCIncrement, 1'b1);
    cycle();

    // Decoder stalls 4 cycles; a stray ack must be ignored
    for (int i = 0; i < 4; i++) begin
      applyStimulus(i == 2, 32'hFFFF0000, 1'b0, 1'b0, 32'h0);
      checkOutput("stall_valid", InstrValid, 1'b1);
      checkOutput("stall_instr", Instr, 32'h12345678);
      checkOutput("stall_instrpc", InstrPC, 32'h5);
      checkOutput("stall_pcwrite", PCWrite, 1'b0);
      checkOutput("stall_memreq", MemReq, 1'b0);
      cycle();
    end
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    cycle();

    // Move to PC=8 via redirect-with-ack from PC=6
    applyStimulus(1'b1, 32'hBAD00006, 1'b0, 1'b1, 32'h8);
    checkOutput("to8_memaddr", MemAddr, 32'h6);
    cycle();

    // Redirect without ack at PC=8 -> DRAIN keeps address 8
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h40);
    checkOutput("drn_memaddr0", MemAddr, 32'h8);
    checkOutput("drn_pcwrite", PCWrite, 1'b1);
    checkOutput("drn_pcload", PCLoad, 32'h40);
    cycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("drn_memreq", MemReq, 1'b1);
    checkOutput("drn_memaddr1", MemAddr, 32'h8);
    checkOutput("drn_idle_pcwrite", PCWrite, 1'b0);
    cycle();
    applyStimulus(1'b1, 32'hBAD00008, 1'b0, 1'b0, 32'h0);
    checkOutput("drn_memaddr2", MemAddr, 32'h8);
    checkOutput("drn_ack_pcwrite", PCWrite, 1'b0);
    cycle();
    applyStimulus(1'b1, 32'hC0000040, 1'b0, 1'b0, 32'h0);
    checkOutput("post_drn_memaddr", MemAddr, 32'h40);
    cycle();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h100);
    checkOutput("post_drn_instr", Instr, 32'hC0000040);
    checkOutput("post_drn_instrpc", InstrPC, 32'h40);

    // Redirect in VALID with InstrReady=1
    checkOutput("vrd_pcwrite", PCWrite, 1'b1);
    checkOutput("vrd_pcinc", PCIncrement, 1'b0);
    checkOutput("vrd_pcload", PCLoad, 32'h100);
    cycle();
    applyStimulus(1'b1, 32'hD0000100, 1'b0, 1'b0, 32'h0);
    checkOutput("vrd_valid_next", InstrValid, 1'b0);
    checkOutput("vrd_memaddr", MemAddr, 32'h100);
    cycle();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("vrd_instrpc", InstrPC, 32'h100);
    cycle();

    // Enter DRAIN, then reset mid-request
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h200);
    checkOutput("pre_rst_memaddr", MemAddr, 32'h101);
    cycle();
    Reset = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("rst_drn_memreq_now", MemReq, 1'b0);
    cycle();
    applyStimulus(1'b1, 32'hBAD0BAD0, 1'b1, 1'b0, 32'h0);
    checkOutput("rst_drn_memreq", MemReq, 1'b0);
    checkOutput("rst_drn_valid", InstrValid, 1'b0);
    checkOutput("rst_drn_pcwrite", PCWrite, 1'b0);
    checkOutput("rst_drn_instr", Instr, 32'h0);
    checkOutput("rst_drn_instrpc", InstrPC, 32'h0);
    cycle();
    Reset = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("rel_pcwrite", PCWrite, 1'b1);
    checkOutput("rel_pcload", PCLoad, 32'h0);
    checkOutput("rel_memreq", MemReq, 1'b0);
    cycle();

    // PC wrap from FFFFFFFF back to 0 is the PC register's business
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b1, 32'hFFFFFFFF);
    checkOutput("wrap_memaddr0", MemAddr, 32'h0);
    cycle();
    applyStimulus(1'b1, 32'hE000FFFF, 1'b0, 1'b0, 32'h0);
    checkOutput("wrap_memaddr1", MemAddr, 32'hFFFFFFFF);
    cycle();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("wrap_instrpc", InstrPC, 32'hFFFFFFFF);
    checkOutput("wrap_instr", Instr, 32'hE000FFFF);
    cycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("wrap_memaddr2", MemAddr, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
